bitonic_sort_loader: RTL and testbench

BITONIC_SORT_LOADER -- requirements
Module: bitonic_sort_loader

---
 rtl/bitonic_sort_loader_pkg.sv | 24 ++
 rtl/bitonic_sort_loader.sv | 105 ++++++++++
 tb/tb_bitonic_sort_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bitonic_sort_loader_pkg.sv
// Shared definitions for the bitonic sort stages: loader state encoding,
// batch-size log2 helper and the all-ones padding constant.
package bitonic_sort_loader_pkg;

  // Loader states; encoding is shared with the other bitonic stages.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2
  } loader_state_e;

  // Widest element any bitonic stage is expected to carry.
  localparam int unsigned MAX_WAY_WIDTH = 1024;

  // Padding value: maximum unsigned, so pads sort to the top in ascending order.
  // Stages slice the low SINGLE_WAY_WIDTH_IN_BITS bits.
  localparam logic [MAX_WAY_WIDTH-1:0] PAD_ALL_ONES = {MAX_WAY_WIDTH{1'b1}};

  // log2 of the batch size (NUM_WAY is a power of two).
  function automatic int unsigned num_way_log2(input int unsigned num_way);
    return $clog2(num_way);
  endfunction

endpackage

// File: rtl/bitonic_sort_loader.sv
// Collects up to NUM_WAY unsigned elements into a flat batch, pads short
// batches with all-ones and holds the batch until the downstream sorter takes it.
module bitonic_sort_loader
  import bitonic_sort_loader_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
  parameter int NUM_WAY                  = 16
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          in_data,
  input  logic                                         in_last,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  out_flatted,
  output logic [num_way_log2(NUM_WAY):0]               out_count
);

  localparam int W    = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int LOG2 = num_way_log2(NUM_WAY);
  localparam int CW   = LOG2 + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_WAY);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [W-1:0]  PAD_VAL  = PAD_ALL_ONES[W-1:0];

  loader_state_e                  state_q, state_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [NUM_WAY-1:0][W-1:0]      slots_q, slots_d;
  logic [CW-1:0]                  count_inc_s;
  logic                           accept_s;

  // Outputs are decoded from state or taken straight from registers.
  assign in_ready    = (state_q == ST_FILL) & ~reset;
  assign out_valid   = (state_q == ST_HOLD);
  assign out_count   = count_q;
  assign out_flatted = slots_q;

  assign accept_s    = in_valid & in_ready;
  assign count_inc_s = count_q + ONE_CNT;

  // Next-state, counter and slot updates for fill, pad and hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slots_d = slots_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          slots_d[count_q[LOG2-1:0]] = in_data;
          count_d                    = count_inc_s;
          if (count_inc_s == FULL_CNT) begin
            state_d = ST_HOLD;
          end else if (in_last) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_PAD: begin
        // Fill every unused slot in a single cycle.
        for (int k = 0; k < NUM_WAY; k++) begin
          if (CW'(k) >= count_q) begin
            slots_d[k] = PAD_VAL;
          end else begin
            slots_d[k] = slots_q[k];
          end
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          count_d = ZERO_CNT;
          state_d = ST_FILL;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FILL;
        count_d = ZERO_CNT;
      end
    endcase
  end

  // State, count and slot registers; reset discards any batch in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      count_q <= ZERO_CNT;
      slots_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slots_q <= slots_d;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_loader.sv
// Self-checking bench for bitonic_sort_loader with NUM_WAY=4, 8-bit elements.
module tb_bitonic_sort_loader;

  localparam int W = 8;
  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W*N-1:0] out_flatted;
  logic [2:0]    out_count;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] vals [N];

  bitonic_sort_loader #(.SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(N)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_flatted(out_flatted), .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: first n slots hold the elements in arrival order, rest are 0xFF.
  function automatic logic [31:0] model_flat(input int n);
    logic [31:0] f;
    f = 32'h0;
    for (int k = 0; k < N; k++) begin
      f[k*W +: W] = (k < n) ? vals[k] : 8'hFF;
    end
    return f;
  endfunction

  // Sends n elements from vals back-to-back, then checks the batch output.
  // Called at a negedge; returns at a negedge with the loader back in FILL.
  task automatic run_batch(input string tag, input int n, input bit last_on_full, input int bp);
    logic [31:0] exp_flat;
    exp_flat = model_flat(n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_in_ready_fill"}, {31'h0, in_ready}, 32'h1);
      in_valid  = 1'b1;
      in_data   = vals[i];
      in_last   = (i == n - 1) ? ((n < N) ? 1'b1 : last_on_full) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      in_last  = 1'($urandom_range(0, 1));
      if (i == n - 1) out_ready = (bp == 0);
      @(negedge clock);
    end
    if (n < N) begin
      check({tag, "_pad_no_valid"}, {31'h0, out_valid}, 32'h0);
      check({tag, "_pad_in_ready"}, {31'h0, in_ready}, 32'h0);
      @(negedge clock);
    end
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_out_flatted"}, out_flatted, exp_flat);
    check({tag, "_out_count"}, {29'h0, out_count}, n);
    check({tag, "_hold_in_ready"}, {31'h0, in_ready}, 32'h0);
    for (int c = 0; c < bp; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(negedge clock);
      check({tag, "_bp_valid"}, {31'h0, out_valid}, 32'h1);
      check({tag, "_bp_flatted"}, out_flatted, exp_flat);
      check({tag, "_bp_count"}, {29'h0, out_count}, n);
      check({tag, "_bp_in_ready"}, {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check({tag, "_after_hs_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_after_hs_in_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_count", {29'h0, out_count}, 32'h0);
    check("rst_out_flatted", out_flatted, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clock);

    // Full batch.
    vals[0] = 8'h05; vals[1] = 8'h01; vals[2] = 8'h09; vals[3] = 8'h03;
    run_batch("full", 4, 1'b0, 0);
    check("full_const", model_flat(4), 32'h03090105);

    // Partial batch of two.
    vals[0] = 8'h07; vals[1] = 8'h02;
    run_batch("partial", 2, 1'b1, 0);
    check("partial_const", model_flat(2), 32'hFFFF0207);

    // Backpressure for 5 cycles.
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    run_batch("bp", 4, 1'b0, 5);

    // in_last on the 4th element: no PAD cycle.
    vals[0] = 8'hA0; vals[1] = 8'hB1; vals[2] = 8'hC2; vals[3] = 8'hD3;
    run_batch("last4", 4, 1'b1, 0);

    // in_last on the 1st element.
    vals[0] = 8'h5A;
    run_batch("last1", 1, 1'b1, 0);

    // Reset mid-batch after two accepts.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
      @(posedge clock); #1; in_valid = 1'b0;
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    check("rst_mid_flatted", out_flatted, 32'h0);
    check("rst_mid_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_rel_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clock);

    // Reset during HOLD.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 8'hDD; in_last = 1'b0;
      @(posedge clock); #1; in_valid = 1'b0;
      @(negedge clock);
    end
    check("pre_rst_hold_valid", {31'h0, out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_hold_valid", {31'h0, out_valid}, 32'h0);
    check("rst_hold_count", {29'h0, out_count}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40;
    run_batch("clean", 4, 1'b0, 0);

    // Randomized batches against the reference model.
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, N);
      for (int i = 0; i < N; i++) vals[i] = 8'($urandom_range(0, 255));
      run_batch("rand", n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
